// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register of the RV32I core.
//
// Owns the PC and keeps at most one instruction-memory request outstanding over a
// req/rvalid handshake. It presents the fetched instruction, its PC and PC+4 to decode.
// It honours the hazard unit's fetch/decode stall and decode flush, and redirects to the
// target resolved in execute.
//
// Ports:
//   iclk, irst          clock, asynchronous active-high reset
//   istall_fetch        hold PC and fetch state
//   istall_decod        hold IF/ID register
//   iflush_decod        load bubble into IF/ID
//   ipc_src_exect       taken branch/jump from execute
//   ipc_target_exect    redirect target (low 2 bits ignored)
//   oimem_req/addr      instruction request and word-aligned address
//   iimem_rvalid/rdata  response (may arrive in the request cycle)
//   oinstr_decod, opc_decod, opc_plus4_decod, ovalid_decod   IF/ID register
//   ofetch_wait         fetch is waiting on memory this cycle
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istall_fetch,
  input  logic        istall_decod,
  input  logic        iflush_decod,
  input  logic        ipc_src_exect,
  input  logic [31:0] ipc_target_exect,
  output logic        oimem_req,
  output logic [31:0] oimem_addr,
  input  logic        iimem_rvalid,
  input  logic [31:0] iimem_rdata,
  output logic [31:0] oinstr_decod,
  output logic [31:0] opc_decod,
  output logic [31:0] opc_plus4_decod,
  output logic        ovalid_decod,
  output logic        ofetch_wait
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_dec_q, pc_dec_d;
  logic [31:0] pc_plus4_dec_q, pc_plus4_dec_d;
  logic        valid_dec_q, valid_dec_d;

  logic        accept;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign accept   = ~istall_decod & ~iflush_decod & ~ipc_src_exect;
  assign pc_plus4 = pc_q + 32'd4;
  assign target   = ipc_target_exect & 32'hFFFF_FFFC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    skid_instr_d  = skid_instr_q;
    skid_valid_d  = skid_valid_q;
    deliver       = 1'b0;
    deliver_instr = skid_instr_q;

    unique case (state_q)
      StIdle: begin
        if (ipc_src_exect) begin
          pc_d = target;
        end
        req_addr_d = pc_d;
        state_d    = StReq;
      end

      // In StReq req_addr always equals pc, so a response belongs to pc.
      StReq: begin
        if (ipc_src_exect) begin
          pc_d = target;
          if (iimem_rvalid) begin
            req_addr_d = target;
          end else begin
            state_d = StDrop;
          end
        end else if (iimem_rvalid) begin
          if (accept && !istall_fetch) begin
            deliver       = 1'b1;
            deliver_instr = iimem_rdata;
            pc_d          = pc_plus4;
            req_addr_d    = pc_plus4;
          end else begin
            // Any reason decode cannot take it (stall or a bare flush): park it.
            skid_instr_d = iimem_rdata;
            skid_valid_d = 1'b1;
            state_d      = StHold;
          end
        end
      end

      StHold: begin
        if (ipc_src_exect) begin
          skid_valid_d = 1'b0;
          pc_d         = target;
          req_addr_d   = target;
          state_d      = StReq;
        end else if (accept && !istall_fetch && skid_valid_q) begin
          deliver       = 1'b1;
          deliver_instr = skid_instr_q;
          skid_valid_d  = 1'b0;
          pc_d          = pc_plus4;
          req_addr_d    = pc_plus4;
          state_d       = StReq;
        end
      end

      // A request is in flight for a stale address; let it finish and discard the data.
      StDrop: begin
        if (ipc_src_exect) begin
          pc_d = target;
        end
        if (iimem_rvalid) begin
          req_addr_d = pc_d;
          state_d    = StReq;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    instr_d        = instr_q;
    pc_dec_d       = pc_dec_q;
    pc_plus4_dec_d = pc_plus4_dec_q;
    valid_dec_d    = valid_dec_q;
    if (iflush_decod || ipc_src_exect || (!istall_decod && !deliver)) begin
      instr_d        = NOP_INSTR;
      pc_dec_d       = 32'h0;
      pc_plus4_dec_d = 32'h0;
      valid_dec_d    = 1'b0;
    end else if (!istall_decod) begin
      instr_d        = deliver_instr;
      pc_dec_d       = pc_q;
      pc_plus4_dec_d = pc_plus4;
      valid_dec_d    = 1'b1;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q        <= StIdle;
      pc_q           <= RESET_PC;
      req_addr_q     <= RESET_PC;
      skid_instr_q   <= NOP_INSTR;
      skid_valid_q   <= 1'b0;
      instr_q        <= NOP_INSTR;
      pc_dec_q       <= 32'h0;
      pc_plus4_dec_q <= 32'h0;
      valid_dec_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      req_addr_q     <= req_addr_d;
      skid_instr_q   <= skid_instr_d;
      skid_valid_q   <= skid_valid_d;
      instr_q        <= instr_d;
      pc_dec_q       <= pc_dec_d;
      pc_plus4_dec_q <= pc_plus4_dec_d;
      valid_dec_q    <= valid_dec_d;
    end
  end

  assign oimem_req       = (state_q == StReq) | (state_q == StDrop);
  assign oimem_addr      = req_addr_q;
  assign oinstr_decod    = instr_q;
  assign opc_decod       = pc_dec_q;
  assign opc_plus4_decod = pc_plus4_dec_q;
  assign ovalid_decod    = valid_dec_q;
  assign ofetch_wait     = ((state_q == StReq) & ~iimem_rvalid) | (state_q == StDrop);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by a randomized run checked
// against an in-order instruction-stream model and handshake rules.
module tb_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src = 1'b0;
  logic [31:0] target = 32'h0;
  logic        imem_req, imem_rvalid, valid_dec, fetch_wait;
  logic [31:0] imem_addr, imem_rdata, instr_dec, pc_dec, pc_plus4_dec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .iclk             (clk),
    .irst             (rst),
    .istall_fetch     (stall_f),
    .istall_decod     (stall_d),
    .iflush_decod     (flush_d),
    .ipc_src_exect    (pc_src),
    .ipc_target_exect (target),
    .oimem_req        (imem_req),
    .oimem_addr       (imem_addr),
    .iimem_rvalid     (imem_rvalid),
    .iimem_rdata      (imem_rdata),
    .oinstr_decod     (instr_dec),
    .opc_decod        (pc_dec),
    .opc_plus4_decod  (pc_plus4_dec),
    .ovalid_decod     (valid_dec),
    .ofetch_wait      (fetch_wait)
  );

  // Memory model: response after a fixed or random number of waiting cycles; data = addr>>2.
  int unsigned wait_cnt;
  int unsigned rand_lat;
  int unsigned fix_lat = 0;
  bit          use_rand = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      rand_lat <= 0;
    end else if (imem_req) begin
      if (imem_rvalid) begin
        wait_cnt <= 0;
        rand_lat <= $urandom_range(0, 2);
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  assign imem_rvalid = imem_req && (wait_cnt >= (use_rand ? rand_lat : fix_lat));
  assign imem_rdata  = imem_addr >> 2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    pc_src  = 1'b0;
    target  = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    check_eq({tag, "_req"}, imem_req, 1'b0);
    check_eq({tag, "_addr"}, imem_addr, 32'h0);
    check_eq({tag, "_instr"}, instr_dec, Nop);
    check_eq({tag, "_pc"}, pc_dec, 32'h0);
    check_eq({tag, "_pc4"}, pc_plus4_dec, 32'h0);
    check_eq({tag, "_valid"}, valid_dec, 1'b0);
    check_eq({tag, "_wait"}, fetch_wait, 1'b0);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic valid);
    check_eq({tag, "_valid"}, valid_dec, valid);
    check_eq({tag, "_instr"}, instr_dec, valid ? (pc >> 2) : Nop);
    check_eq({tag, "_pc"}, pc_dec, valid ? pc : 32'h0);
    check_eq({tag, "_pc4"}, pc_plus4_dec, valid ? pc + 32'd4 : 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Random-phase model state
  logic [31:0] exp_pc, prev_instr, prev_pc, prev_pc4, prev_addr;
  logic        prev_valid, prev_kill, prev_hold, prev_pending;
  int          n_deliv;

  initial begin
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_async");

    // Zero-wait memory: one instruction per cycle from reset.
    do_reset();
    check_eq("t1_c0_req", imem_req, 1'b0);
    tick();
    check_eq("t1_c1_req", imem_req, 1'b1);
    check_eq("t1_c1_addr", imem_addr, 32'h0);
    check_eq("t1_c1_valid", valid_dec, 1'b0);
    tick(); chk_ifid("t1_c2", 32'h0, 1'b1);
    tick(); chk_ifid("t1_c3", 32'h4, 1'b1);
    tick(); chk_ifid("t1_c4", 32'h8, 1'b1);
    check_eq("t1_c4_addr", imem_addr, 32'hC);

    // Two-cycle latency memory.
    fix_lat = 2;
    do_reset();
    tick();
    check_eq("t2_c1_addr", imem_addr, 32'h0);
    check_eq("t2_c1_wait", fetch_wait, 1'b1);
    chk_ifid("t2_c1", 32'h0, 1'b0);
    tick();
    check_eq("t2_c2_addr", imem_addr, 32'h0);
    check_eq("t2_c2_wait", fetch_wait, 1'b1);
    chk_ifid("t2_c2", 32'h0, 1'b0);
    tick();
    check_eq("t2_c3_addr", imem_addr, 32'h0);
    check_eq("t2_c3_wait", fetch_wait, 1'b0);
    chk_ifid("t2_c3", 32'h0, 1'b0);
    tick();
    chk_ifid("t2_c4", 32'h0, 1'b1);
    check_eq("t2_c4_addr", imem_addr, 32'h4);

    // Stall fetch and decode for three cycles as a response arrives.
    fix_lat = 0;
    do_reset();
    tick();
    tick(); chk_ifid("t3_c2", 32'h0, 1'b1);
    stall_f = 1'b1; stall_d = 1'b1;
    tick(); check_eq("t3_c3_req", imem_req, 1'b0); chk_ifid("t3_c3", 32'h0, 1'b1);
    tick(); check_eq("t3_c4_req", imem_req, 1'b0); chk_ifid("t3_c4", 32'h0, 1'b1);
    tick(); check_eq("t3_c5_req", imem_req, 1'b0); chk_ifid("t3_c5", 32'h0, 1'b1);
    stall_f = 1'b0; stall_d = 1'b0;
    tick(); chk_ifid("t3_c6", 32'h4, 1'b1);
    check_eq("t3_c6_req", imem_req, 1'b1);
    check_eq("t3_c6_addr", imem_addr, 32'h8);

    // Redirect while a request is outstanding.
    do_reset();
    tick();
    tick(); chk_ifid("t4_c2", 32'h0, 1'b1);
    fix_lat = 2; pc_src = 1'b1; target = 32'h100;
    tick();
    chk_ifid("t4_c3", 32'h0, 1'b0);
    check_eq("t4_c3_req", imem_req, 1'b1);
    check_eq("t4_c3_addr", imem_addr, 32'h4);
    check_eq("t4_c3_wait", fetch_wait, 1'b1);
    pc_src = 1'b0;
    tick();
    check_eq("t4_c4_addr", imem_addr, 32'h4);
    check_eq("t4_c4_wait", fetch_wait, 1'b1);
    tick();
    check_eq("t4_c5_addr", imem_addr, 32'h100);
    chk_ifid("t4_c5", 32'h0, 1'b0);
    fix_lat = 0;
    tick(); chk_ifid("t4_c6", 32'h100, 1'b1);

    // Redirect in the same cycle as a response.
    do_reset();
    tick();
    tick(); chk_ifid("t5_c2", 32'h0, 1'b1);
    pc_src = 1'b1; target = 32'h200;
    tick();
    check_eq("t5_c3_req", imem_req, 1'b1);
    check_eq("t5_c3_addr", imem_addr, 32'h200);
    chk_ifid("t5_c3", 32'h0, 1'b0);
    pc_src = 1'b0;
    tick(); chk_ifid("t5_c4", 32'h200, 1'b1);

    // Unaligned target, PC wrap, then reset while waiting.
    do_reset();
    tick();
    pc_src = 1'b1; target = 32'hFFFF_FFFF;
    tick();
    check_eq("t6_c2_addr", imem_addr, 32'hFFFF_FFFC);
    pc_src = 1'b0;
    tick();
    chk_ifid("t6_c3", 32'hFFFF_FFFC, 1'b1);
    check_eq("t6_c3_addr", imem_addr, 32'h0);
    fix_lat = 2;
    tick();
    check_eq("t6_c4_wait", fetch_wait, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_midrst");

    // Randomized run.
    use_rand = 1'b1;
    fix_lat  = 0;
    do_reset();
    exp_pc       = 32'h0;
    prev_instr   = Nop;
    prev_pc      = 32'h0;
    prev_pc4     = 32'h0;
    prev_valid   = 1'b0;
    prev_kill    = 1'b0;
    prev_hold    = 1'b0;
    prev_pending = 1'b0;
    prev_addr    = 32'h0;
    n_deliv      = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (prev_kill) begin
        check_eq("rnd_kill_valid", valid_dec, 1'b0);
        check_eq("rnd_kill_instr", instr_dec, Nop);
        check_eq("rnd_kill_pc", pc_dec, 32'h0);
      end else if (prev_hold) begin
        check_eq("rnd_hold_instr", instr_dec, prev_instr);
        check_eq("rnd_hold_pc", pc_dec, prev_pc);
        check_eq("rnd_hold_valid", valid_dec, prev_valid);
      end else if (valid_dec) begin
        check_eq("rnd_pc", pc_dec, exp_pc);
        check_eq("rnd_instr", instr_dec, exp_pc >> 2);
        check_eq("rnd_pc4", pc_plus4_dec, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end else begin
        check_eq("rnd_bubble_instr", instr_dec, Nop);
        check_eq("rnd_bubble_pc", pc_dec, 32'h0);
      end
      if (prev_pending) begin
        check_eq("rnd_req_kept", imem_req, 1'b1);
        check_eq("rnd_addr_stable", imem_addr, prev_addr);
      end
      check_eq("rnd_addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
      if (!imem_req) begin
        check_eq("rnd_wait_idle", fetch_wait, 1'b0);
      end else if (!imem_rvalid) begin
        check_eq("rnd_wait_busy", fetch_wait, 1'b1);
      end

      prev_instr   = instr_dec;
      prev_pc      = pc_dec;
      prev_pc4     = pc_plus4_dec;
      prev_valid   = valid_dec;
      prev_pending = imem_req && !imem_rvalid;
      prev_addr    = imem_addr;

      stall_f = ($urandom_range(0, 99) < 12);
      stall_d = ($urandom_range(0, 99) < 12);
      flush_d = ($urandom_range(0, 99) < 5);
      pc_src  = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 3) == 0) begin
        target = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      end else begin
        target = $urandom & 32'h0000_0FFF;
      end
      prev_kill = flush_d || pc_src;
      prev_hold = stall_d;
      if (pc_src) begin
        exp_pc = target & 32'hFFFF_FFFC;
      end
    end
    check_eq("rnd_progress", (n_deliv > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core. It owns the PC and issues one instruction-memory request at a time over a req/rvalid handshake. It presents the fetched instruction, its PC and PC+4 to decode. It obeys the fetch/decode stall and decode flush produced by the hazard unit, and redirects to the branch/jump target resolved in execute.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: bubble encoding (addi x0,x0,0).

Ports (clock and reset first):
- iclk  in  1  core clock; all state updates on its rising edge.
- irst  in  1  reset; asynchronous, active-high.
- istall_fetch  in  1  hazard unit: hold PC and fetch state.
- istall_decod  in  1  hazard unit: hold IF/ID register.
- iflush_decod  in  1  hazard unit: load bubble into IF/ID.
- ipc_src_exect  in  1  taken branch/jump resolved in execute.
- ipc_target_exect  in  32  redirect target.
- oimem_req  out  1  instruction request valid.
- oimem_addr  out  32  request address; word aligned.
- iimem_rvalid  in  1  response valid; completes the outstanding request, may arrive in the same cycle as the request.
- iimem_rdata  in  32  instruction word, valid with iimem_rvalid.
- oinstr_decod  out  32  IF/ID instruction.
- opc_decod  out  32  IF/ID PC.
- opc_plus4_decod  out  32  IF/ID PC+4.
- ovalid_decod  out  1  IF/ID holds a real instruction.
- ofetch_wait  out  1  fetch is waiting on memory this cycle.

## Operation
- Registers:
  - pc: next instruction to deliver.
  - req_addr: drives oimem_addr.
  - skid: instruction plus valid bit.
  - state: IDLE, REQ, HOLD or DROP.
- oimem_req = (state==REQ) | (state==DROP). oimem_addr = req_addr.
- While oimem_req is high and iimem_rvalid is low, req_addr is held stable. Requests are never aborted.
- accept = ~istall_decod & ~iflush_decod & ~ipc_src_exect.
- State transitions (first matching rule applies):
  - IDLE: next cycle goes to REQ with req_addr = pc.
  - REQ, ipc_src_exect: discard any response; pc and target take ipc_target_exect. If rvalid, stay REQ with req_addr = target. Otherwise go DROP.
  - REQ, rvalid & accept & ~istall_fetch: IF/ID <= {rdata, pc, pc+4, valid=1}; pc <= pc+4; req_addr <= pc+4; stay REQ.
  - REQ, rvalid & stall (istall_decod or istall_fetch): capture rdata into skid; go HOLD.
  - REQ, no rvalid: stay REQ.
  - HOLD: oimem_req low.
    - ipc_src_exect: drop skid; pc and req_addr take the target; go REQ.
    - accept & ~istall_fetch: IF/ID <= skid; pc <= pc+4; req_addr <= pc+4; go REQ.
  - DROP: waits for the stale response and discards it.
    - ipc_src_exect: pc is overwritten by the newer target.
    - On rvalid: req_addr <= pc; go REQ.
- IF/ID update priority:
  - iflush_decod or ipc_src_exect: {NOP_INSTR, 0, 0, valid=0}.
  - else istall_decod: hold.
  - else if an instruction is delivered this cycle: load it.
  - else: bubble {NOP_INSTR, 0, 0, valid=0}.
- ofetch_wait = ((state==REQ) & ~iimem_rvalid) | (state==DROP).
- Arithmetic: pc+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000. A redirect target's low 2 bits are forced to 0.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; pc=req_addr=RESET_PC; skid invalid.
  - oimem_req=0; oimem_addr=RESET_PC.
  - oinstr_decod=NOP_INSTR; opc_decod=0; opc_plus4_decod=0; ovalid_decod=0; ofetch_wait=0.
- First request: oimem_req rises in the first cycle after irst deasserts.
- Latency: zero-wait memory delivers one instruction per cycle. Each rvalid-to-IF/ID step takes one edge.
- Redirect: the target request is issued in the cycle after ipc_src_exect if no request is outstanding. Otherwise it is issued in the cycle after the stale rvalid.
- Reset mid-request: the outstanding response is ignored; the memory must tolerate a dropped request.

## Test plan
- Reset release with zero-wait memory returning addr>>2 as data: req at cycle 1, addr 0x0. IF/ID sequence 0x0/0x4/0x8 with ovalid_decod=1 each cycle.
- Memory with 2-cycle latency: oimem_addr stays stable over 3 cycles with ofetch_wait=1 for 2 of them. IF/ID shows a bubble (ovalid_decod=0, NOP_INSTR) until data arrives.
- istall_fetch=istall_decod=1 for 3 cycles as rvalid arrives: state goes to HOLD, oimem_req=0 and IF/ID is frozen. On release the skid instruction loads and the next req is at pc+4.
- ipc_src_exect with target 0x100 while a request is outstanding:
  - The stale response is discarded.
  - The next req is at 0x100.
  - IF/ID is flushed (valid 0) in the redirect cycle.
- Redirect and rvalid in the same cycle: the rvalid data is discarded and the req at the target is issued on the next cycle.
- PC at 0xFFFF_FFFC accepted: the next request address is 0x0000_0000. Asserting irst mid-wait returns all outputs to their reset values immediately.
